// File: rtl/iter_div.sv
// rtl/iter_div.sv - radix-2 restoring iterative unsigned divider
module iter_div #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quot,
  output logic [WIDTH-1:0] rem,
  output logic             dbz
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state, state_nxt;
  logic             accept;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   prem;
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] dvs;
  logic             zpend;

  // One restoring step: shift in the next dividend bit, trial-subtract the divisor.
  // prem < dvs always holds, so the shifted value fits WIDTH+1 bits and the
  // top bit of the difference is a clean sign bit.
  logic [WIDTH:0] shifted, diff, prem_nxt;
  logic           qbit;
  assign shifted  = {prem[WIDTH-1:0], dvd[WIDTH-1]};
  assign diff     = shifted - {1'b0, dvs};
  assign qbit     = ~diff[WIDTH];
  assign prem_nxt = qbit ? diff : shifted;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and start acceptance; a zero divisor waits one cycle in IDLE
  // (zpend) so its done pulse follows the accepting edge by one clock.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        if (zpend) begin
          state_nxt = DONE;
        end else if (start) begin
          accept    = 1'b1;
          state_nxt = (b == '0) ? IDLE : CALC;
        end
      end
      CALC: begin
        busy = 1'b1;
        if (cnt == LAST) state_nxt = DONE;
      end
      DONE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = (b == '0) ? IDLE : CALC;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture, iteration datapath and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      prem  <= '0;
      dvd   <= '0;
      dvs   <= '0;
      zpend <= 1'b0;
      done  <= 1'b0;
      quot  <= '0;
      rem   <= '0;
      dbz   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        dvd   <= a;
        dvs   <= b;
        prem  <= '0;
        cnt   <= '0;
        zpend <= (b == '0);
      end else if (zpend) begin
        quot  <= '1;
        rem   <= dvd;
        dbz   <= 1'b1;
        done  <= 1'b1;
        zpend <= 1'b0;
      end else if (state == CALC) begin
        prem <= prem_nxt;
        dvd  <= {dvd[WIDTH-2:0], qbit};
        cnt  <= cnt + 1'b1;
        if (cnt == LAST) begin
          quot <= {dvd[WIDTH-2:0], qbit};
          rem  <= prem_nxt[WIDTH-1:0];
          dbz  <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_iter_div.sv
// tb/tb_iter_div.sv - scoreboard bench for iter_div
module tb_iter_div;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a, b;
  logic         busy, done, dbz;
  logic [W-1:0] quot, rem;

  iter_div #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .quot(quot), .rem(rem), .dbz(dbz)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] a, b, q, r;
    logic         z;
    int           at_edge;
  } exp_t;

  exp_t sb[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Called at a falling edge; the next rising edge (index cyc+1) accepts it.
  task automatic issue(input logic [W-1:0] ai, input logic [W-1:0] bi);
    exp_t e;
    e.a = ai;
    e.b = bi;
    if (bi == '0) begin
      e.q = '1; e.r = ai; e.z = 1'b1; e.at_edge = cyc + 2;
    end else begin
      e.q = ai / bi; e.r = ai % bi; e.z = 1'b0; e.at_edge = cyc + 1 + W;
    end
    sb.push_back(e);
    a = ai; b = bi; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output logic saw_busy);
    saw_busy = busy;
    for (int k = 0; k < 60 && !done; k++) begin
      @(negedge clk);
      saw_busy = saw_busy | busy;
    end
    if (!done) check("done_timeout", 0, 1);
  endtask

  // Scoreboard: every done pulse retires the oldest expectation.
  always @(negedge clk) begin
    if (done) begin
      if (sb.size() == 0) begin
        check("spurious_done", 1, 0);
      end else begin
        exp_t e;
        logic [63:0] lhs;
        e = sb.pop_front();
        check("quot", quot, e.q);
        check("rem", rem, e.r);
        check("dbz", dbz, e.z);
        check("latency", cyc, e.at_edge);
        check("busy_at_done", busy, 0);
        if (!e.z) begin
          lhs = 64'(quot) * 64'(e.b) + 64'(rem);
          check("identity", (lhs == 64'(e.a)) && (rem < e.b), 1);
        end
      end
    end
  end

  initial begin
    logic sb_busy;
    int   n0, dones;
    logic [W-1:0] ra, rb;

    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_quot", quot, 0);
    check("rst_rem", rem, 0);
    check("rst_dbz", dbz, 0);
    rst = 1'b0;

    issue(32'd100, 32'd7);
    check("busy_after_start", busy, 1);
    wait_done(sb_busy);
    @(negedge clk);

    issue(32'hFFFF_FFFF, 32'd1);
    wait_done(sb_busy);
    @(negedge clk);
    issue(32'd3, 32'd10);
    wait_done(sb_busy);
    @(negedge clk);

    issue(32'd5, 32'd0);
    wait_done(sb_busy);
    check("dbz_busy_seen", sb_busy, 0);
    repeat (3) @(negedge clk);
    check("hold_quot", quot, 32'hFFFF_FFFF);
    check("hold_rem", rem, 32'd5);
    check("hold_dbz", dbz, 1);

    issue(32'd100, 32'd7);
    n0 = cyc;
    while (cyc < n0 + 9) @(negedge clk);
    a = 32'd50; b = 32'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = '0; b = '0;
    wait_done(sb_busy);
    dones = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("ignored_start_dones", dones, 0);

    issue(32'd1000, 32'd3);
    n0 = cyc;
    while (cyc < n0 + 16) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_quot", quot, 0);
    check("midrst_rem", rem, 0);
    check("midrst_dbz", dbz, 0);
    sb.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    dones = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("aborted_dones", dones, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    issue(32'd1000, 32'd3);
    wait_done(sb_busy);
    @(negedge clk);

    for (int i = 0; i < 1500; i++) begin
      ra = $urandom;
      case ($urandom_range(0, 7))
        0:       rb = '0;
        1, 2:    rb = $urandom_range(1, 15);
        3:       rb = ra + 32'd1;
        4:       rb = ra;
        default: rb = $urandom;
      endcase
      issue(ra, rb);
      wait_done(sb_busy);
    end
    repeat (3) @(negedge clk);
    check("sb_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
